road_gen: RTL and testbench
===========================

# road_gen

Road-shape generator driving the road line memory's `new_x_offset` input; the producer side of the `need_new_line` / `new_x_offset` shift protocol. Each line the memory shifts in (one per `clk` while `need_new_line` is high), the generator supplies a straight/left/right step and updates its own copy of the new top line's left edge. An LFSR-driven segment FSM alternates straight runs with curves and keeps the road inside the screen.

## Interface
- `INITIAL_X`, 7'h12: reset left-edge block; must equal the road memory's initial left-edge value.
- `MIN_X`, 2: smallest permitted left-edge block.
- `MAX_X`, 52: largest permitted left-edge block; 80 blocks minus the 26-block road minus 2.
- `START_LINES`, 64: length of the guaranteed straight segment after reset, in lines.
- `CURVE_STEP`, 2: a curve shifts one block every `CURVE_STEP` lines; range 1..15.
- `SEED`, 16'hACE1: LFSR reset value; must be non-zero.
- `clk` in 1: system clock.
- `resetN` in 1: synchronous, active-low reset.
- `need_new_line` in 1: from the road memory. High at a rising edge = one line consumed (a "consume edge").
- `run` in 1: high = race running. Low = road held straight and generator frozen.
- `new_x_offset` out 2: step for the next consumed line. 2'b00 = straight, 2'b01 = +1 block (right), 2'b11 = −1 block (left). 2'b10 is never driven.
- `road_x` out 7: mirror of the road memory's top-line left edge.
- `curve_active` out 1: FSM is in `S_CURVE`.
- `curve_dir` out 1: direction of the current or last curve; 1 = right, 0 = left.

## Operation
- Every state update occurs only on a consume edge with `resetN` = 1. No other edge changes state.
- On a consume edge, the road memory applies the current registered `new_x_offset`. On the same edge the generator:
  - updates `road_x` by that offset (+1, −1 or 0, 7-bit);
  - advances the LFSR once;
  - registers the next offset.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1. Shift left; feedback bit = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]. Field draws below use the pre-advance value.
- `seg_cnt` is 8 bits and counts remaining lines in the segment. `step_cnt` is 4 bits.
- `S_STRAIGHT`:
  - next offset is 00;
  - `seg_cnt` decrements on each consume edge;
  - on the consume edge where `seg_cnt` = 1: go to `S_CURVE`, set `seg_cnt` = 16 + lfsr[5:0], `curve_dir` = lfsr[7], `step_cnt` = `CURVE_STEP`.
- `S_CURVE`, on each consume edge:
  - decrement `seg_cnt` and `step_cnt`;
  - when `step_cnt` reaches 0, next offset is the direction code (01 or 11) and `step_cnt` reloads to `CURVE_STEP`; otherwise next offset is 00.
  - Bound rule: if the step would move the updated `road_x` above `MAX_X` or below `MIN_X`, next offset is forced to 00 and the FSM goes to `S_STRAIGHT` early.
  - On the consume edge where `seg_cnt` = 1: go to `S_STRAIGHT` with `seg_cnt` = 32 + lfsr[6:0].
- With `run` = 0 on a consume edge:
  - next offset is 00;
  - FSM, `seg_cnt`, `step_cnt` and LFSR hold;
  - `road_x` still applies the offset that was already registered.
- Invariant: `MIN_X` ≤ `road_x` ≤ `MAX_X` at all times, so the 7-bit value never wraps.

## Timing
- Reset values:
  - `new_x_offset` = 00
  - `road_x` = `INITIAL_X`
  - `curve_active` = 0
  - `curve_dir` = 0
  - state `S_STRAIGHT`, `seg_cnt` = `START_LINES`, `step_cnt` = `CURVE_STEP`, LFSR = `SEED`
- `new_x_offset` is registered with one-line latency. The value present at a consume edge was decided on the previous consume edge. A multi-cycle `need_new_line` burst therefore receives a fresh offset every cycle.
- Reset asserted mid-burst wins over `need_new_line`. Any step already registered is discarded.
- Dropping `run` takes effect one line late: at most one further non-zero step may be applied.
- `road_x` after a consume edge equals the road memory's top-line left edge after the same edge.

## Configuration
- `ROAD_GEN_SEED_EN`:
  - Defined: adds input port `seed` [15:0]. The LFSR loads `seed` on reset, or `SEED` if `seed` = 0.
  - Undefined: no port; the LFSR resets to `SEED`.

## Test plan
- Reset, then 64 consume edges with `run` = 1 → `new_x_offset` = 00 throughout, `road_x` = 7'h12, and `curve_active` rises on the 64th edge.
- `SEED` = 16'hACE1, first curve → `curve_dir` = lfsr[7] of the state after 64 advances (compare against a bench LFSR model). `road_x` changes by 1 every 2 lines, and `curve_active` is high for 16 + lfsr[5:0] lines.
- `INITIAL_X` = 51 with a forced right curve → exactly one +1 step to 52, then 00 and `curve_active` = 0; `road_x` never exceeds 52.
- `run` dropped while a registered 01 is pending → one more +1 is applied, then 00 indefinitely; counters and LFSR are unchanged when `run` returns high.
- Reset asserted during a 5-cycle `need_new_line` burst in mid-curve → next cycle shows `new_x_offset` = 00, `road_x` = 7'h12, `curve_active` = 0.
- `ROAD_GEN_SEED_EN` defined, `seed` = 0 → identical sequence to `SEED` = 16'hACE1; `seed` = 16'h0001 → a different curve sequence.

Source files
------------

// File: rtl/road_gen.sv
// ---------------------------------------------------------------------------
// road_gen
//
// Road-shape generator. It produces the left-edge steps for the road line
// memory. Each time the memory consumes a line (need_new_line high at a
// rising clk edge), this block hands over a straight / left / right step and
// keeps its own copy of the new top line's left edge. A 16-bit LFSR drives a
// two-state segment machine. The machine alternates straight runs with
// curves and never lets the road leave the screen.
//
// Ports
//   clk            in  1   system clock
//   resetN         in  1   synchronous, active-low reset
//   need_new_line  in  1   one line consumed per rising edge while high
//   run            in  1   high = race running; low = road held straight,
//                          generator frozen
//   seed           in  16  (only with ROAD_GEN_SEED_EN) LFSR reset value,
//                          zero selects SEED
//   new_x_offset   out 2   step for the next consumed line:
//                          00 straight, 01 +1 block, 11 -1 block
//   road_x         out 7   mirror of the road memory's top-line left edge
//   curve_active   out 1   segment machine is in a curve
//   curve_dir      out 1   direction of current/last curve, 1 = right
//
// Configuration macro
//   ROAD_GEN_SEED_EN  defined: adds the 'seed' input port. The LFSR loads
//                     'seed' on reset, or SEED when 'seed' is zero.
//                     undefined: no port; the LFSR resets to SEED.
// ---------------------------------------------------------------------------
module road_gen #(
   parameter logic [6:0]  INITIAL_X   = 7'h12,
   parameter int          MIN_X       = 2,
   parameter int          MAX_X       = 52,
   parameter int          START_LINES = 64,
   parameter int          CURVE_STEP  = 2,
   parameter logic [15:0] SEED        = 16'hACE1
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        need_new_line,
   input  logic        run,
`ifdef ROAD_GEN_SEED_EN
   input  logic [15:0] seed,
`endif
   output logic [1:0]  new_x_offset,
   output logic [6:0]  road_x,
   output logic        curve_active,
   output logic        curve_dir
);

   // Parameters narrowed once to the widths of the registers they meet.
   localparam logic [6:0] MIN_X7    = MIN_X[6:0];
   localparam logic [6:0] MAX_X7    = MAX_X[6:0];
   localparam logic [7:0] START8    = START_LINES[7:0];
   localparam logic [3:0] STEP4     = CURVE_STEP[3:0];

   localparam logic [1:0] OFF_NONE  = 2'b00;
   localparam logic [1:0] OFF_RIGHT = 2'b01;
   localparam logic [1:0] OFF_LEFT  = 2'b11;

   typedef enum logic [0:0] {
      S_STRAIGHT = 1'b0,
      S_CURVE    = 1'b1
   } seg_state_t;

   seg_state_t  state;
   logic [7:0]  seg_cnt;
   logic [3:0]  step_cnt;
   logic [15:0] lfsr;

   logic        lfsr_fb;
   logic [15:0] lfsr_adv;
   logic [15:0] seed_init;
   logic [6:0]  x_next;
   logic        step_due;
   logic        dir_blocked;
   logic [7:0]  curve_len;
   logic [7:0]  straight_len;

   // The reset seed. With the seed port enabled, a zero on the port falls
   // back to the SEED parameter. This keeps the LFSR out of its all-zero
   // lock-up state.
`ifdef ROAD_GEN_SEED_EN
   assign seed_init = (seed == 16'h0000) ? SEED : seed;
`else
   assign seed_init = SEED;
`endif

   // Fibonacci LFSR for x^16+x^14+x^13+x^11+1, shifting left. The taps
   // listed as bit indices are 15, 13, 12 and 10.
   assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
   assign lfsr_adv = {lfsr[14:0], lfsr_fb};

   // Left edge after this consume edge: the already-registered step is
   // sign-extended and added. The bound rule guarantees the sum stays
   // inside MIN_X..MAX_X, so the 7-bit add never wraps.
   assign x_next = road_x + {{5{new_x_offset[1]}}, new_x_offset};

   // A curve step is due when step_cnt would decrement to zero on this
   // edge. The step is blocked when it would push the edge just computed
   // past the screen limits in the curve's direction.
   assign step_due    = (step_cnt == 4'd1);
   assign dir_blocked = curve_dir ? (x_next >= MAX_X7) : (x_next <= MIN_X7);

   // Segment lengths drawn from the pre-advance LFSR value.
   assign curve_len    = 8'd16 + {2'b00, lfsr[5:0]};
   assign straight_len = 8'd32 + {1'b0,  lfsr[6:0]};

   // Segment machine and all registered outputs.
   // Nothing moves unless a line is consumed. On a consume edge the
   // registered step is always applied to road_x, because the road memory
   // applies it on the same edge. The offset defaults to straight and is
   // overwritten only when a curve step goes out. With run low, the LFSR,
   // counters and state hold, so the road resumes exactly where it paused.
   // When a curve ends normally and its final step lands on the same edge,
   // both actions happen: the step is still issued, and the machine returns
   // to straight. If the bound rule fires, the step is suppressed and the
   // curve ends early with a fresh straight length.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         state        <= S_STRAIGHT;
         seg_cnt      <= START8;
         step_cnt     <= STEP4;
         lfsr         <= seed_init;
         new_x_offset <= OFF_NONE;
         road_x       <= INITIAL_X;
         curve_active <= 1'b0;
         curve_dir    <= 1'b0;
      end else if (need_new_line) begin
         road_x       <= x_next;
         new_x_offset <= OFF_NONE;
         if (run) begin
            lfsr <= lfsr_adv;
            case (state)
               S_STRAIGHT: begin
                  if (seg_cnt == 8'd1) begin
                     state        <= S_CURVE;
                     curve_active <= 1'b1;
                     seg_cnt      <= curve_len;
                     curve_dir    <= lfsr[7];
                     step_cnt     <= STEP4;
                  end else begin
                     seg_cnt <= seg_cnt - 8'd1;
                  end
               end
               S_CURVE: begin
                  seg_cnt <= seg_cnt - 8'd1;
                  if (step_due) begin
                     step_cnt <= STEP4;
                     if (dir_blocked) begin
                        state        <= S_STRAIGHT;
                        curve_active <= 1'b0;
                        seg_cnt      <= straight_len;
                     end else begin
                        new_x_offset <= curve_dir ? OFF_RIGHT : OFF_LEFT;
                     end
                  end else begin
                     step_cnt <= step_cnt - 4'd1;
                  end
                  if (seg_cnt == 8'd1) begin
                     state        <= S_STRAIGHT;
                     curve_active <= 1'b0;
                     seg_cnt      <= straight_len;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_road_gen.sv
// ---------------------------------------------------------------------------
// tb_road_gen
//
// Self-checking bench for road_gen. Three instances run from the same
// stimulus:
//   0: default parameters
//   1: starts one block below the right limit
//   2: starts one block above the left limit, steps every line, short start
// A line-level reference model for each instance predicts every output
// after every clock.
// ---------------------------------------------------------------------------
module tb_road_gen;

   localparam int NI    = 3;
   localparam int MINX  = 2;
   localparam int MAXX  = 52;

   typedef struct {
      int          ix;
      int          cs;
      int          start;
      int          x;
      int          pend;
      bit          curve;
      int          left;
      int          step;
      bit          dir;
      logic [15:0] lfsr;
   } model_t;

   model_t mdl [NI];

   logic clk           = 1'b0;
   logic resetN        = 1'b0;
   logic need_new_line = 1'b0;
   logic run           = 1'b0;

   logic [NI-1:0][1:0] off_w;
   logic [NI-1:0][6:0] x_w;
   logic [NI-1:0]      ca_w;
   logic [NI-1:0]      cd_w;

   int checks = 0;
   int errors = 0;

`ifdef ROAD_GEN_SEED_EN
   logic [15:0] seed_val = 16'h0000;
`endif

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   road_gen #(.INITIAL_X(7'd18)) u_mid (
      .clk(clk), .resetN(resetN), .need_new_line(need_new_line), .run(run),
`ifdef ROAD_GEN_SEED_EN
      .seed(seed_val),
`endif
      .new_x_offset(off_w[0]), .road_x(x_w[0]),
      .curve_active(ca_w[0]), .curve_dir(cd_w[0]));

   road_gen #(.INITIAL_X(7'd51)) u_hi (
      .clk(clk), .resetN(resetN), .need_new_line(need_new_line), .run(run),
`ifdef ROAD_GEN_SEED_EN
      .seed(seed_val),
`endif
      .new_x_offset(off_w[1]), .road_x(x_w[1]),
      .curve_active(ca_w[1]), .curve_dir(cd_w[1]));

   road_gen #(.INITIAL_X(7'd3), .CURVE_STEP(1), .START_LINES(8)) u_lo (
      .clk(clk), .resetN(resetN), .need_new_line(need_new_line), .run(run),
`ifdef ROAD_GEN_SEED_EN
      .seed(seed_val),
`endif
      .new_x_offset(off_w[2]), .road_x(x_w[2]),
      .curve_active(ca_w[2]), .curve_dir(cd_w[2]));

   // One comparison: count it and report a mismatch.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // Drive the three inputs between clock edges.
   task automatic applyStimulus(input bit nnl, input bit rn, input bit rst_n);
      need_new_line = nnl;
      run           = rn;
      resetN        = rst_n;
   endtask

   // Reference LFSR: taps at x^16, x^14, x^13, x^11, shifting left.
   function automatic logic [15:0] lfsrNext(input logic [15:0] v);
      logic fb;
      fb = v[15] ^ v[13] ^ v[12] ^ v[10];
      return {v[14:0], fb};
   endfunction

   function automatic int offCode(input int p);
      if (p == 1)  return 1;
      if (p == -1) return 3;
      return 0;
   endfunction

   task automatic modelReset(input int i);
      mdl[i].x     = mdl[i].ix;
      mdl[i].pend  = 0;
      mdl[i].curve = 1'b0;
      mdl[i].left  = mdl[i].start;
      mdl[i].step  = mdl[i].cs;
      mdl[i].dir   = 1'b0;
`ifdef ROAD_GEN_SEED_EN
      mdl[i].lfsr  = (seed_val == 16'h0000) ? 16'hACE1 : seed_val;
`else
      mdl[i].lfsr  = 16'hACE1;
`endif
   endtask

   // One consumed line in road terms: apply the pending step, then decide
   // the step for the following line from the segment rules.
   function automatic model_t modelStep(input model_t m, input bit rn);
      model_t      r;
      logic [15:0] draw;
      bit          ending;
      int          target;
      r      = m;
      r.x    = m.x + m.pend;
      r.pend = 0;
      if (rn) begin
         draw   = m.lfsr;
         r.lfsr = lfsrNext(m.lfsr);
         if (!m.curve) begin
            if (m.left == 1) begin
               r.curve = 1'b1;
               r.left  = 16 + int'(draw[5:0]);
               r.dir   = draw[7];
               r.step  = m.cs;
            end else begin
               r.left = m.left - 1;
            end
         end else begin
            ending = (m.left == 1);
            r.left = m.left - 1;
            r.step = m.step - 1;
            if (r.step == 0) begin
               r.step = m.cs;
               target = r.x + (m.dir ? 1 : -1);
               if (target > MAXX || target < MINX) begin
                  r.curve = 1'b0;
                  r.left  = 32 + int'(draw[6:0]);
               end else begin
                  r.pend = m.dir ? 1 : -1;
               end
            end
            if (ending) begin
               r.curve = 1'b0;
               r.left  = 32 + int'(draw[6:0]);
            end
         end
      end
      return r;
   endfunction

   task automatic checkAll();
      for (int i = 0; i < NI; i++) begin
         checkOutput($sformatf("offset%0d", i), int'(off_w[i]), offCode(mdl[i].pend));
         checkOutput($sformatf("road_x%0d", i), int'(x_w[i]), mdl[i].x);
         checkOutput($sformatf("curve_active%0d", i), int'(ca_w[i]), int'(mdl[i].curve));
         checkOutput($sformatf("curve_dir%0d", i), int'(cd_w[i]), int'(mdl[i].dir));
         checkOutput($sformatf("in_range%0d", i),
                     int'(x_w[i] >= 7'(MINX) && x_w[i] <= 7'(MAXX)), 1);
      end
   endtask

   // Advance one clock: update every model from the inputs the DUTs saw,
   // then compare just after the edge.
   task automatic cycle();
      @(posedge clk);
      for (int i = 0; i < NI; i++) begin
         if (!resetN)
            modelReset(i);
         else if (need_new_line)
            mdl[i] = modelStep(mdl[i], run);
      end
      #1;
      checkAll();
   endtask

   task automatic randomRun(input int n);
      bit r;
      r = 1'b1;
      for (int k = 0; k < n; k++) begin
         if ($urandom_range(0, 99) < 3)
            r = ~r;
         applyStimulus($urandom_range(0, 9) < 7, r, $urandom_range(0, 599) != 0);
         cycle();
      end
   endtask

   initial begin
      bit found;

      mdl[0].ix = 18; mdl[0].cs = 2; mdl[0].start = 64;
      mdl[1].ix = 51; mdl[1].cs = 2; mdl[1].start = 64;
      mdl[2].ix = 3;  mdl[2].cs = 1; mdl[2].start = 8;
      for (int i = 0; i < NI; i++)
         modelReset(i);

      $display("[TB] reset");
      applyStimulus(1'b1, 1'b1, 1'b0);
      repeat (3) cycle();

      $display("[TB] start straight of 64 lines");
      applyStimulus(1'b1, 1'b1, 1'b1);
      repeat (64) cycle();
      checkOutput("start_curve", int'(ca_w[0]), 1);
      checkOutput("start_x", int'(x_w[0]), 18);

      $display("[TB] run dropped with a step pending");
      found = 1'b0;
      for (int k = 0; k < 600 && !found; k++) begin
         applyStimulus($urandom_range(0, 3) != 0, 1'b1, 1'b1);
         cycle();
         if (mdl[0].pend != 0 && mdl[1].pend != 0)
            found = 1'b1;
      end
      checkOutput("find_pending", int'(found), 1);
      applyStimulus(1'b1, 1'b0, 1'b1);
      repeat (12) cycle();
      checkOutput("frozen_offset", int'(off_w[0]), 0);
      applyStimulus(1'b1, 1'b1, 1'b1);
      repeat (30) cycle();

      $display("[TB] reset inside a burst mid-curve");
      found = 1'b0;
      for (int k = 0; k < 2000 && !found; k++) begin
         applyStimulus($urandom_range(0, 3) != 0, 1'b1, 1'b1);
         cycle();
         if (mdl[0].curve && mdl[0].left > 8)
            found = 1'b1;
      end
      checkOutput("find_curve", int'(found), 1);
      applyStimulus(1'b1, 1'b1, 1'b1);
      repeat (2) cycle();
      applyStimulus(1'b1, 1'b1, 1'b0);
      cycle();
      checkOutput("burst_reset_x", int'(x_w[0]), 18);
      checkOutput("burst_reset_off", int'(off_w[0]), 0);
      checkOutput("burst_reset_curve", int'(ca_w[0]), 0);
      applyStimulus(1'b1, 1'b1, 1'b1);
      repeat (2) cycle();

      $display("[TB] randomized traffic");
      randomRun(6000);

`ifdef ROAD_GEN_SEED_EN
      $display("[TB] seed port = 1");
      seed_val = 16'h0001;
      applyStimulus(1'b1, 1'b1, 1'b0);
      repeat (2) cycle();
      randomRun(1500);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
